// File: rtl/iob_rtc_gen.sv
// rtl/iob_rtc_gen.sv - NCO real-time clock source for the machine timer, IOb register interface
module iob_rtc_gen #(
    parameter int          ADDR_W  = 16,
    parameter int          DATA_W  = 32,
    parameter int          ACC_W   = 32,
    parameter logic [31:0] INC_RST = 32'h0015798F,
    parameter logic        EN_RST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready,
    output logic                  rt_clk,
    output logic                  tick
);

    localparam int NB = DATA_W / 8;

    logic              wr;
    logic              rd;
    logic [1:0]        reg_sel;
    logic              ctrl_wr;
    logic              inc_wr;
    logic              clear;
    logic              enable;
    logic [ACC_W-1:0]  inc;
    logic [ACC_W-1:0]  acc;
    logic              rt_clk_q;
    logic [31:0]       ticks;
    logic [DATA_W-1:0] inc_ext;
    logic [DATA_W-1:0] acc_ext;
    logic [DATA_W-1:0] inc_new;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_addr;

    assign wr          = valid && (|wstrb);
    assign rd          = valid && !(|wstrb);
    assign reg_sel     = address[3:2];
    assign ctrl_wr     = wr && (reg_sel == 2'd0);
    assign inc_wr      = wr && (reg_sel == 2'd1);
    assign clear       = ctrl_wr && wstrb[0] && wdata[1];
    assign tick        = rt_clk & ~rt_clk_q;
    assign unused_addr = ^{address[ADDR_W-1:4], address[1:0]};

    always_comb begin
        inc_ext              = '0;
        inc_ext[ACC_W-1:0]   = inc;
        acc_ext              = '0;
        acc_ext[ACC_W-1:0]   = acc;
    end

    // Byte-granular merge of the write data into the current increment
    always_comb begin
        inc_new = inc_ext;
        for (int b = 0; b < NB; b++) begin
            if (wstrb[b]) begin
                inc_new[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            2'd0:    rd_mux[0] = enable;
            2'd1:    rd_mux    = inc_ext;
            2'd2:    rd_mux    = ticks;
            default: rd_mux    = acc_ext;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable <= EN_RST;
            inc    <= INC_RST[ACC_W-1:0];
        end else begin
            if (ctrl_wr && wstrb[0]) begin
                enable <= wdata[0];
            end
            if (inc_wr) begin
                inc <= inc_new[ACC_W-1:0];
            end
        end
    end

    // Clear wins over the increment and over a coincident tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            rt_clk   <= 1'b0;
            rt_clk_q <= 1'b0;
            ticks    <= '0;
        end else if (clear) begin
            acc      <= '0;
            rt_clk   <= 1'b0;
            rt_clk_q <= 1'b0;
            ticks    <= '0;
        end else begin
            rt_clk_q <= rt_clk;
            if (enable) begin
                acc    <= acc + inc;
                rt_clk <= acc[ACC_W-1];
            end
            if (tick) begin
                ticks <= ticks + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= valid;
            if (rd) begin
                rdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_iob_rtc_gen.sv
// tb/tb_iob_rtc_gen.sv - directed table-driven bench for iob_rtc_gen
module tb_iob_rtc_gen;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [15:0] address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic        rt_clk;
    logic        tick;

    int checks = 0;
    int errors = 0;

    iob_rtc_gen dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .address (address),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .rdata   (rdata),
        .ready   (ready),
        .rt_clk  (rt_clk),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Called at a negedge; the write commits at the following posedge
    task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        valid   = 1'b1;
        address = a;
        wdata   = d;
        wstrb   = s;
        @(negedge clk);
        valid = 1'b0;
        wstrb = 4'h0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
        valid   = 1'b1;
        address = a;
        wstrb   = 4'h0;
        @(negedge clk);
        chk("ready", {31'd0, ready}, 32'd1);
        d     = rdata;
        valid = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        seen_hi;
        rst     = 1'b1;
        valid   = 1'b0;
        address = '0;
        wdata   = '0;
        wstrb   = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst ready",  {31'd0, ready},  32'd0);
        chk("rst rdata",  rdata,           32'd0);
        chk("rst rt_clk", {31'd0, rt_clk}, 32'd0);
        chk("rst tick",   {31'd0, tick},   32'd0);
        rst = 1'b0;

        // default rate after reset
        bus_read(16'h0, d); chk("ctrl rst", d, 32'h1);
        bus_read(16'h4, d); chk("inc rst",  d, 32'h0015798F);
        seen_hi = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (rt_clk) seen_hi = 1'b1;
        end
        chk("rt_clk toggles", {31'd0, seen_hi}, 32'd1);
        bus_read(16'h8, d);
        chk("ticks 10k range", {31'd0, (d >= 32'd3 && d <= 32'd4)}, 32'd1);

        // INC = 1/4 turn: acc sequence and 4-clk rt_clk period
        bus_write(16'h4, 32'h40000000, 4'hF);
        bus_write(16'h0, 32'h3, 4'hF);
        bus_read(16'hC, d); chk("acc e1", d, 32'h00000000);
        bus_read(16'hC, d); chk("acc e2", d, 32'h40000000);
        bus_read(16'hC, d); chk("acc e3", d, 32'h80000000);
        bus_read(16'hC, d); chk("acc e4", d, 32'hC0000000);
        bus_read(16'hC, d); chk("acc e5", d, 32'h00000000);
        for (int n = 6; n <= 40; n++) begin
            @(negedge clk);
            chk($sformatf("rt_clk n%0d", n), {31'd0, rt_clk}, {31'd0, ((n % 4) == 3) || ((n % 4) == 0)});
            chk($sformatf("tick n%0d", n),   {31'd0, tick},   {31'd0, ((n % 4) == 3)});
        end
        bus_read(16'h8, d); chk("ticks 40clk", d, 32'd10);

        // disable mid-run freezes everything
        bus_write(16'h0, 32'h0, 4'hF);
        repeat (50) @(negedge clk);
        chk("frozen rt_clk", {31'd0, rt_clk}, 32'd0);
        bus_read(16'hC, d); chk("frozen acc",   d, 32'h80000000);
        bus_read(16'h8, d); chk("frozen ticks", d, 32'd10);
        bus_write(16'h0, 32'h1, 4'hF);
        chk("resume rt_clk f0", {31'd0, rt_clk}, 32'd0);
        @(negedge clk);
        chk("resume rt_clk f1", {31'd0, rt_clk}, 32'd1);
        chk("resume tick f1",   {31'd0, tick},   32'd1);
        bus_read(16'hC, d); chk("resume acc",   d, 32'hC0000000);
        bus_read(16'h8, d); chk("resume ticks", d, 32'd11);

        // clear on the same edge as a tick
        bus_write(16'h0, 32'h3, 4'hF);
        repeat (3) @(negedge clk);
        chk("tick before clear", {31'd0, tick}, 32'd1);
        bus_write(16'h0, 32'h3, 4'hF);
        bus_read(16'h8, d); chk("ticks after clear", d, 32'd0);
        bus_read(16'h0, d); chk("ctrl clear reads 0", d, 32'h1);
        repeat (2) @(negedge clk);
        bus_read(16'h8, d); chk("ticks first edge", d, 32'd1);

        // TICKS wrap
        bus_write(16'h0, 32'h2, 4'hF);
        bus_write(16'h4, 32'h80000000, 4'hF);
        force dut.ticks = 32'hFFFFFFFF;
        #1;
        release dut.ticks;
        bus_read(16'h8, d); chk("ticks preload", d, 32'hFFFFFFFF);
        bus_write(16'h0, 32'h1, 4'hF);
        repeat (2) @(negedge clk);
        chk("wrap tick", {31'd0, tick}, 32'd1);
        @(negedge clk);
        bus_read(16'h8, d); chk("ticks wrapped", d, 32'd0);

        // register map vectors, NCO stopped and cleared
        vecs[0] = '{16'h4, 32'h12345678, 4'hF, 32'h12345678};
        vecs[1] = '{16'h4, 32'hAABBCCDD, 4'h1, 32'h123456DD};
        vecs[2] = '{16'h4, 32'h00EE0000, 4'h4, 32'h12EE56DD};
        vecs[3] = '{16'h4, 32'hFF000000, 4'h8, 32'hFFEE56DD};
        vecs[4] = '{16'h4, 32'h99999999, 4'h0, 32'hFFEE56DD};
        vecs[5] = '{16'h0, 32'hFFFFFFFC, 4'hF, 32'h00000000};
        vecs[6] = '{16'h8, 32'h00000055, 4'hF, 32'h00000000};
        vecs[7] = '{16'hC, 32'h00000077, 4'hF, 32'h00000000};
        vecs[8] = '{16'h0, 32'h00000001, 4'h1, 32'h00000001};
        vecs[9] = '{16'h0, 32'h00000003, 4'h2, 32'h00000001};
        bus_write(16'h0, 32'h2, 4'hF);
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wstrb != 4'h0) bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            bus_read(vecs[i].addr, d);
            chk($sformatf("vec%0d", i), d, vecs[i].exp);
        end
        @(negedge clk);
        chk("ready drops", {31'd0, ready}, 32'd0);

        // reset with a read in flight
        valid   = 1'b1;
        address = 16'h4;
        wstrb   = 4'h0;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("inflight ready", {31'd0, ready}, 32'd0);
        chk("inflight rdata", rdata, 32'd0);
        valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus_read(16'h0, d); chk("ctrl after rst", d, 32'h1);
        bus_read(16'h4, d); chk("inc after rst",  d, 32'h0015798F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
